// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave that oversamples sclk/cs/mosi on sysclk and decodes 24-bit command frames.
// An optional host-supplied response frame is shifted out on miso during the same transaction.
`timescale 1ns/1ps

module spi_frame_slave #(
    parameter int CMD_BITS     = 8,
    parameter int ADDR_BITS    = 8,
    parameter int PAYLOAD_BITS = 8,
    parameter int FRAME_WIDTH  = CMD_BITS + ADDR_BITS + PAYLOAD_BITS
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic                    sclk,
    input  logic                    cs,
    input  logic                    mosi,
    input  logic                    slv_tx_enb,
    input  logic [FRAME_WIDTH-1:0]  i_slv_frame,
    output logic                    miso,
    output logic [CMD_BITS-1:0]     o_cmd,
    output logic [ADDR_BITS-1:0]    o_addr,
    output logic [PAYLOAD_BITS-1:0] o_payload
);

    // state | meaning
    // IDLE  | cs high, waiting for a falling edge of cs
    // RECV  | cs low, shifting bits 0..FRAME_WIDTH-1
    // DONE  | full frame captured, sclk ignored until cs rises
    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    localparam int CNT_W = $clog2(FRAME_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_WIDTH - 1);

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_WIDTH-2:0] rx_sh;
    logic [FRAME_WIDTH-1:0] tx_sh;
    logic [FRAME_WIDTH-1:0] rx_next;

    logic sclk_meta, sclk_sync, sclk_prev;
    logic cs_meta, cs_sync, cs_prev;
    logic mosi_meta, mosi_sync;
    logic sclk_rise, cs_fall, cs_rise;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            cs_meta   <= 1'b0;
            cs_sync   <= 1'b0;
            cs_prev   <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            cs_meta   <= cs;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign cs_fall   = ~cs_sync & cs_prev;
    assign cs_rise   = cs_sync & ~cs_prev;

    // The frame word including the bit being sampled this cycle
    assign rx_next = {rx_sh, mosi_sync};

    // tx_sh is zero outside RECV, so miso comes straight from a flop
    assign miso = tx_sh[FRAME_WIDTH-1];

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            o_cmd     <= '0;
            o_addr    <= '0;
            o_payload <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                        rx_sh   <= '0;
                        tx_sh   <= slv_tx_enb ? i_slv_frame : '0;
                    end
                end
                RECV: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        tx_sh <= '0;
                    end else if (sclk_rise) begin
                        rx_sh   <= rx_next[FRAME_WIDTH-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state     <= DONE;
                            tx_sh     <= '0;
                            o_cmd     <= rx_next[FRAME_WIDTH-1 -: CMD_BITS];
                            o_addr    <= rx_next[PAYLOAD_BITS +: ADDR_BITS];
                            o_payload <= rx_next[0 +: PAYLOAD_BITS];
                        end else begin
                            tx_sh <= {tx_sh[FRAME_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_sh <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: an SPI master driver plus a pin-level monitor that
// checks decoded outputs against a queue of expected frames.
`timescale 1ns/1ps

module tb_spi_frame_slave;

    logic        sysclk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        slv_tx_enb = 1'b0;
    logic [23:0] i_slv_frame = 24'h0;
    logic        miso;
    logic [7:0]  o_cmd;
    logic [7:0]  o_addr;
    logic [7:0]  o_payload;

    int errors = 0;
    int checks = 0;

    logic [23:0] exp_q[$];
    logic [23:0] last_good = 24'h0;
    int          bitcnt = 0;
    event        frame_done;

    spi_frame_slave dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .slv_tx_enb (slv_tx_enb),
        .i_slv_frame(i_slv_frame),
        .miso       (miso),
        .o_cmd      (o_cmd),
        .o_addr     (o_addr),
        .o_payload  (o_payload)
    );

    always #4 sysclk = ~sysclk;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: counts sclk rising edges at the pins while cs is low
    always @(negedge cs) bitcnt = 0;

    always @(posedge sclk) begin
        if (!cs && !rst) begin
            bitcnt++;
            if (bitcnt == 24) -> frame_done;
        end
    end

    always begin
        logic [23:0] want;
        @(frame_done);
        repeat (3) @(posedge sysclk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got frame %h expected none queued", {o_cmd, o_addr, o_payload});
        end else begin
            want = exp_q.pop_front();
            check("frame_out", {o_cmd, o_addr, o_payload}, want);
            last_good = want;
        end
    end

    always begin
        @(posedge cs);
        if (!rst) begin
            repeat (3) @(posedge sysclk);
            #1;
            check("hold_after_cs", {o_cmd, o_addr, o_payload}, last_good);
        end
    end

    always @(posedge rst) begin
        last_good = 24'h0;
        exp_q.delete();
    end

    // Master side: mosi changes with sclk low, miso captured on sclk rising
    task automatic clock_bit(input logic b, output logic m);
        mosi = b;
        #19 sclk = 1'b1;
        m = miso;
        #19 sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] data, input int nbits, input int extra,
                              input logic tx_en, input logic [23:0] tx_frame, input int gap);
        logic [23:0] cap;
        logic [23:0] exp_m;
        logic [23:0] extra_ones;
        logic        m;
        cap = 24'h0;
        extra_ones = 24'h0;
        slv_tx_enb = tx_en;
        i_slv_frame = tx_frame;
        if (nbits == 24) exp_q.push_back(data);
        cs = 1'b0;
        #40;
        slv_tx_enb = 1'($urandom_range(0, 1));
        i_slv_frame = 24'($urandom);
        for (int i = 0; i < nbits; i++) begin
            clock_bit(data[23-i], m);
            cap = {cap[22:0], m};
        end
        for (int i = 0; i < extra; i++) begin
            clock_bit(1'($urandom_range(0, 1)), m);
            if (m) extra_ones++;
        end
        #10;
        exp_m = tx_en ? tx_frame : 24'h0;
        exp_m = exp_m >> (24 - nbits);
        check("miso_frame", cap, exp_m);
        if (extra > 0) check("miso_extra", extra_ones, 24'h0);
        if (nbits == 24) check("miso_done", {23'h0, miso}, 24'h0);
        cs = 1'b1;
        #(gap);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        m;
        logic [23:0] rdata;
        logic [23:0] rtx;
        int          nb;
        int          ex;

        #1 rst = 1'b1;
        #1;
        check("reset_outputs", {o_cmd, o_addr, o_payload}, 24'h0);
        check("reset_miso", {23'h0, miso}, 24'h0);
        #29.5 rst = 1'b0;
        #40;

        send_frame(24'h80A0D0, 24, 0, 1'b0, 24'h0, 60);
        send_frame(24'h123456, 24, 0, 1'b1, 24'hC35A96, 60);
        send_frame(24'h9E3C71, 24, 0, 1'b0, 24'hFFFFFF, 60);

        send_frame(24'h80A0D0, 24, 0, 1'b1, 24'h5A5A5A, 60);
        send_frame(24'hFFFFFF, 10, 0, 1'b1, 24'hFFFFFF, 60);
        send_frame(24'h010203, 24, 0, 1'b0, 24'h0, 60);

        slv_tx_enb = 1'b1;
        i_slv_frame = 24'hFFFFFF;
        cs = 1'b0;
        #40;
        for (int i = 0; i < 10; i++) clock_bit(1'($urandom_range(0, 1)), m);
        check("miso_pre_reset", {23'h0, m}, 24'h1);
        #5 rst = 1'b1;
        #1;
        check("midframe_reset_outputs", {o_cmd, o_addr, o_payload}, 24'h0);
        check("midframe_reset_miso", {23'h0, miso}, 24'h0);
        #29 rst = 1'b0;
        #40 cs = 1'b1;
        #60;
        send_frame(24'hC0FFEE, 24, 0, 1'b1, 24'h3C3C3C, 60);

        send_frame(24'hAAAAAA, 24, 30, 1'b1, 24'hF0F00F, 24);
        send_frame(24'h555555, 24, 30, 1'b1, 24'h0FF0F0, 60);

        for (int k = 0; k < 16; k++) begin
            rdata = 24'($urandom);
            rtx = 24'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 23)) : 24;
            ex = (nb == 24) ? int'($urandom_range(0, 4)) : 0;
            send_frame(rdata, nb, ex, 1'($urandom_range(0, 1)), rtx, int'($urandom_range(24, 60)));
        end

        #200;
        check("scoreboard_drained", 24'(exp_q.size()), 24'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
